// File: rtl/dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lsu_master
// Description : Initiator to the word-organised data memory. Takes RV32
//               load/store requests, extracts and extends load bytes/halves,
//               and does read-modify-write for sub-word stores.
//               Optional feature macro: DMEM_SUBWORD_STORE_EN (RMW sub-word
//               stores; when undefined, byte/half stores return an error).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_master #(
    parameter int ADDRW = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,

    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [1:0]       i_req_size,
    input  logic             i_req_unsigned,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [3:0]       i_req_tag,

    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_rdata,
    output logic [3:0]       o_rsp_tag,
    output logic             o_rsp_err,

    output logic             o_mem_valid,
    output logic             o_mem_we,
    output logic [ADDRW-1:0] o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    input  logic             i_mem_ready,
    input  logic [31:0]      i_mem_rdata
);

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
`ifdef DMEM_SUBWORD_STORE_EN
        S_RMW_RD = 3'd2,
        S_MERGE  = 3'd3,
`endif
        S_WR     = 3'd4,
        S_RSP    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_req_err;

    logic        w_unused_addr;
    assign w_unused_addr = ^i_req_addr[31:ADDRW+2];

    function automatic logic [31:0] f_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            c_SIZE_BYTE: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            c_SIZE_HALF: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default:     res = word;
        endcase
        return res;
    endfunction

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_misaligned = (i_req_size == 2'd3)
                       || ((i_req_size == c_SIZE_HALF) && i_req_addr[0])
                       || ((i_req_size == c_SIZE_WORD) && (i_req_addr[1:0] != 2'b00));

`ifdef DMEM_SUBWORD_STORE_EN
    assign w_req_err = w_misaligned;
`else
    // Without byte enables or RMW support, sub-word stores cannot be honoured.
    assign w_req_err = w_misaligned || (i_req_we && (i_req_size != c_SIZE_WORD));
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_req_ready  = 1'b0;
        o_mem_valid  = 1'b0;
        o_mem_we     = 1'b0;
        o_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = !i_rst;
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = S_RSP;
                    end else if (!i_req_we) begin
                        w_next_state = S_RD;
                    end else if (i_req_size == c_SIZE_WORD) begin
                        w_next_state = S_WR;
                    end else begin
`ifdef DMEM_SUBWORD_STORE_EN
                        w_next_state = S_RMW_RD;
`else
                        w_next_state = S_RSP;
`endif
                    end
                end
            end
            S_RD: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) w_next_state = S_RSP;
            end
`ifdef DMEM_SUBWORD_STORE_EN
            S_RMW_RD: begin
                o_mem_valid = 1'b1;
                if (i_mem_ready) w_next_state = S_MERGE;
            end
            S_MERGE: begin
                w_next_state = S_WR;
            end
`endif
            S_WR: begin
                o_mem_valid = 1'b1;
                o_mem_we    = 1'b1;
                if (i_mem_ready) w_next_state = S_RSP;
            end
            S_RSP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

`ifdef DMEM_SUBWORD_STORE_EN
    logic [31:0] r_word;

    function automatic logic [31:0] f_merge(
        input logic [31:0] word,
        input logic [15:0] data,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = word;
        if (size == c_SIZE_BYTE) begin
            case (lane)
                2'd0:    res[7:0]   = data[7:0];
                2'd1:    res[15:8]  = data[7:0];
                2'd2:    res[23:16] = data[7:0];
                default: res[31:24] = data[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = data;
        end else begin
            res[15:0] = data;
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_word <= 32'd0;
        end else if ((r_state == S_RMW_RD) && i_mem_ready) begin
            r_word <= i_mem_rdata;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_addr  <= '0;
            o_mem_wdata <= 32'd0;
            o_rsp_rdata <= 32'd0;
            o_rsp_tag   <= 4'd0;
            o_rsp_err   <= 1'b0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_lane      <= 2'd0;
        end else begin
            if (w_accept) begin
                o_mem_addr  <= i_req_addr[ADDRW+1:2];
                o_mem_wdata <= i_req_wdata;
                o_rsp_rdata <= 32'd0;
                o_rsp_tag   <= i_req_tag;
                o_rsp_err   <= w_req_err;
                r_size      <= i_req_size;
                r_unsigned  <= i_req_unsigned;
                r_lane      <= i_req_addr[1:0];
            end
            if ((r_state == S_RD) && i_mem_ready) begin
                o_rsp_rdata <= f_extract(i_mem_rdata, r_size, r_lane, r_unsigned);
            end
`ifdef DMEM_SUBWORD_STORE_EN
            // o_mem_wdata still holds the right-aligned store data until here.
            if (r_state == S_MERGE) begin
                o_mem_wdata <= f_merge(r_word, o_mem_wdata[15:0], r_size, r_lane);
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_lsu_master
// Description : Directed self-checking bench for dmem_lsu_master with a
//               1-cycle registered-ready memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_master;
    localparam int ADDRW = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]       req_size;
    logic [31:0]      req_addr, req_wdata;
    logic [3:0]       req_tag;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_rdata;
    logic [3:0]       rsp_tag;
    logic             mem_valid, mem_we, mem_ready;
    logic [ADDRW-1:0] mem_addr;
    logic [31:0]      mem_wdata, mem_rdata;

    logic [31:0]      mem [0:1023];
    logic [31:0]      shadow [0:7];

    int n_tests = 0;
    int n_fail  = 0;
    int gap_viol = 0;
    int mem_valid_cycles = 0;
    logic prev_done;

    logic [31:0] g_rd;
    logic        g_err;
    logic [3:0]  g_tag;
    int          g_lat;
    int          mv0;

    always #5 clk = ~clk;

    dmem_lsu_master #(.ADDRW(ADDRW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_tag      (req_tag),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_tag      (rsp_tag),
        .o_rsp_err      (rsp_err),
        .o_mem_valid    (mem_valid),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_ready    (mem_ready),
        .i_mem_rdata    (mem_rdata)
    );

    // Memory: ready is registered from valid, so it pulses one cycle after valid rises.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= mem_valid && !mem_ready;
            if (mem_valid && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (prev_done && mem_valid) gap_viol <= gap_viol + 1;
            if (mem_valid) mem_valid_cycles <= mem_valid_cycles + 1;
            prev_done <= mem_valid && mem_ready;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] tag,
                          output logic [31:0] rdata, output logic err, output logic [3:0] rtag,
                          output int lat);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata; err = rsp_err; rtag = rsp_tag;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] tag,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        logic [3:0]  tg;
        int          lt;
        do_req(we, size, uns, addr, wdata, tag, rd, er, tg, lt);
        check({name, ".rdata"}, rd, exp_rdata);
        check({name, ".err"}, {31'b0, er}, {31'b0, exp_err});
        check({name, ".tag"}, {28'b0, tg}, {28'b0, tag});
        check({name, ".lat"}, lt, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_tag = 4'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", {31'b0, req_ready}, 32'd0);
        check("rst.mem_valid", {31'b0, mem_valid}, 32'd0);
        check("rst.mem_we",    {31'b0, mem_we},    32'd0);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst.mem_addr",  {22'b0, mem_addr},  32'd0);
        check("rst.mem_wdata", mem_wdata,          32'd0);
        check("rst.rsp_rdata", rsp_rdata,          32'd0);
        check("rst.rsp_tag",   {28'b0, rsp_tag},   32'd0);
        rst = 1'b0;
        #1;
        check("rel.req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // Word store then load
        run("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 4'd1, 32'h0, 1'b0, 3);
        check("mem4", mem[4], 32'hDEADBEEF);
        run("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd2, 32'hDEADBEEF, 1'b0, 3);

        // Byte/half extraction from 0x80FF7F01
        run("sw20",  1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 4'd3, 32'h0, 1'b0, 3);
        run("lb23",  1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 4'd4, 32'hFFFFFF80, 1'b0, 3);
        run("lbu23", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 4'd5, 32'h00000080, 1'b0, 3);
        run("lh22",  1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 4'd6, 32'hFFFF80FF, 1'b0, 3);
        run("lb21",  1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 4'd7, 32'h0000007F, 1'b0, 3);
        run("lb22",  1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 4'd8, 32'hFFFFFFFF, 1'b0, 3);
        run("lbu22", 1'b0, 2'd0, 1'b1, 32'h22, 32'h0, 4'd9, 32'h000000FF, 1'b0, 3);
        run("lhu20", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 4'd10, 32'h00007F01, 1'b0, 3);
        run("lhu22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 4'd11, 32'h000080FF, 1'b0, 3);

        // Sub-word stores
        run("sw30", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, 4'd12, 32'h0, 1'b0, 3);
`ifdef DMEM_SUBWORD_STORE_EN
        run("sb31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, 4'd13, 32'h0, 1'b0, 6);
        check("mem12.sb", mem[12], 32'h1122AA44);
        run("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 4'd14, 32'h0, 1'b0, 6);
        run("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 4'd15, 32'hBEEFAA44, 1'b0, 3);
`else
        run("sb31", 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000AA, 4'd13, 32'h0, 1'b1, 1);
        run("sh32", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 4'd14, 32'h0, 1'b1, 1);
        check("mem12.unchanged", mem[12], 32'h11223344);
        run("lw30", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 4'd15, 32'h11223344, 1'b0, 3);
`endif

        // Misalignment: no memory activity at all
        mv0 = mem_valid_cycles;
        run("lw41",  1'b0, 2'd2, 1'b0, 32'h41, 32'h0,    4'd1, 32'h0, 1'b1, 1);
        run("sh43",  1'b1, 2'd1, 1'b0, 32'h43, 32'h1234, 4'd2, 32'h0, 1'b1, 1);
        run("ld_s3", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0,    4'd3, 32'h0, 1'b1, 1);
        run("st_s3", 1'b1, 2'd3, 1'b0, 32'h40, 32'h5,    4'd4, 32'h0, 1'b1, 1);
        check("misalign.no_mem", mem_valid_cycles - mv0, 32'd0);

        // Back-pressure on the response
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd6, g_rd, g_err, g_tag, g_lat);
        check("bp.lat", g_lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.valid", {31'b0, rsp_valid}, 32'd1);
            check("bp.rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp.tag",   {28'b0, rsp_tag}, 32'd6);
            check("bp.req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.released", {31'b0, rsp_valid}, 32'd0);
        check("bp.idle_ready", {31'b0, req_ready}, 32'd1);

        // Random back-to-back word traffic over words 64..71
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            do_req(1'b1, 2'd2, 1'b0, 32'h100 + 32'(i * 4), shadow[i], 4'(i), g_rd, g_err, g_tag, g_lat);
        end
        for (int i = 0; i < 40; i++) begin
            int idx;
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                shadow[idx] = $urandom;
                do_req(1'b1, 2'd2, 1'b0, 32'h100 + 32'(idx * 4), shadow[idx], 4'(i), g_rd, g_err, g_tag, g_lat);
                check("rnd.st_err", {31'b0, g_err}, 32'd0);
            end else begin
                do_req(1'b0, 2'd2, 1'b0, 32'h100 + 32'(idx * 4), 32'h0, 4'(i), g_rd, g_err, g_tag, g_lat);
                check("rnd.ld_data", g_rd, shadow[idx]);
            end
        end
        check("rnd.gap", gap_viol, 0);

        // Reset during WR
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h55555555; req_tag = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstwr.in_wr", {30'b0, mem_valid, mem_we}, 32'd3);
        rst = 1'b1;
        #1;
        check("rstwr.mem_valid_drop", {31'b0, mem_valid}, 32'd0);
        check("rstwr.no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rstwr.req_ready_rst", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rstwr.req_ready_rel", {31'b0, req_ready}, 32'd1);
        check("rstwr.mem4_kept", mem[4], 32'hDEADBEEF);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (rsp_valid) seen++;
            end
            check("rstwr.no_rsp_after", seen, 0);
        end
        run("lw10_post", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'd3, 32'hDEADBEEF, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_lsu_master.md
# dmem_lsu_master

Memory-side initiator for the word-organised data memory: accepts byte-addressed RV32 load/store requests from the load/store pipeline and drives the memory's valid/we/addr/wdata, ready/rdata handshake. Performs byte-lane extraction with sign/zero extension for loads. Performs read-modify-write for sub-word stores, because the memory has no byte enables. Sits between the LSU issue stage and the data memory.

## Interface
- ADDRW, 10: word-address width of the data memory.
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  reset. Asynchronous, active-high.
- i_req_valid  in  1  request offered.
- o_req_ready  out  1  request accepted when both valid and ready are high.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as misaligned.
- i_req_unsigned  in  1  zero-extend load (LBU/LHU).
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_tag  in  4  opaque ID, returned with the response.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed when both valid and ready are high.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_tag  out  4  captured i_req_tag.
- o_rsp_err  out  1  misaligned or unsupported access; memory was not touched.
- o_mem_valid, o_mem_we  out  1 each  memory request.
- o_mem_addr  out  ADDRW  i_req_addr[ADDRW+1:2].
- o_mem_wdata  out  32  full word to write.
- i_mem_ready  in  1  memory completion; i_mem_rdata is valid in the same cycle.
- i_mem_rdata  in  32  memory read word.

## Operation
- States: IDLE, RD, RMW_RD, MERGE, WR, RSP.
- IDLE: o_req_ready=1. On accept, capture all request fields, then take the first matching branch:
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0; size=3): go to RSP with err=1.
  - Load: go to RD.
  - Word store: go to WR with wdata as given.
  - Sub-word store: go to RMW_RD.
- RD and RMW_RD drive o_mem_valid=1, o_mem_we=0. Address, we and wdata are held stable until i_mem_ready. On i_mem_ready, capture i_mem_rdata.
  - RD: go to RSP.
  - RMW_RD: go to MERGE.
- Load extraction:
  - Byte: lane = addr[1:0].
  - Half: lane = addr[1].
  - Sign-extend unless unsigned. Word loads pass through unchanged.
- MERGE: o_mem_valid=0. Replace the addressed byte with wdata[7:0], or the addressed half with wdata[15:0], in the captured word. Go to WR.
- WR: o_mem_valid=1, o_mem_we=1 until i_mem_ready, then go to RSP.
- RSP: o_rsp_valid=1, o_mem_valid=0. All o_rsp_* fields are held stable until i_rsp_ready, then go to IDLE.
- The memory requires o_mem_valid low for at least one cycle between transactions, because its ready flag is registered from valid. MERGE and RSP guarantee this gap. No path asserts o_mem_valid in two back-to-back transactions without an intervening low cycle.
- One request is outstanding at a time. No request is accepted outside IDLE.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - o_mem_valid, o_mem_we, o_rsp_valid, o_rsp_err = 0.
  - o_mem_addr, o_mem_wdata, o_rsp_rdata, o_rsp_tag = 0.
  - o_req_ready = 0 while i_rst is high, 1 in the first cycle after release.
- Latencies assume a 1-cycle memory; accept happens in cycle 0.
  - Load / word store: o_mem_valid in cycle 1, i_mem_ready in cycle 2, o_rsp_valid in cycle 3.
  - Sub-word store: read in cycles 1–2, MERGE in cycle 3, write in cycles 4–5, o_rsp_valid in cycle 6.
  - Error: o_rsp_valid in cycle 1, with no memory activity.
- A slower memory extends RD, RMW_RD and WR indefinitely; there is no timeout.
- Back-pressure: while i_rsp_ready=0 in RSP, the block stays there. With i_rsp_ready tied high, the next accept occurs 1 cycle after o_rsp_valid.
- Reset mid-operation: the transaction is abandoned and no response is produced. o_mem_valid drops immediately.

## Configuration
- DMEM_SUBWORD_STORE_EN defined: sub-word stores use the RMW path described above.
- DMEM_SUBWORD_STORE_EN undefined:
  - RMW_RD and MERGE are not built.
  - Aligned byte and half stores return o_rsp_err=1 in cycle 1, without a memory access.
  - Loads and word stores are unchanged.

## Test plan
- Word store then word load: store addr 0x10, data 0xDEADBEEF, then load 0x10.
  - Memory sees write at word 4.
  - Load response rdata=0xDEADBEEF, err=0, tag echoed, load rsp 3 cycles after accept.
- Signed/unsigned byte: word 0x80FF7F01 at 0x20.
  - LB at 0x23 → 0xFFFFFF80.
  - LBU at 0x23 → 0x00000080.
  - LH at 0x22 → 0xFFFF80FF.
- Sub-word RMW: word 0x11223344 at 0x30.
  - SB 0xAA to 0x31, then SH 0xBEEF to 0x32, then LW 0x30 → 0xBEEFAA44.
  - Each store response arrives in cycle 6.
  - With the macro undefined, the SB returns err=1 instead and memory is unchanged.
- Misalignment: LW at 0x41, SH at 0x43 and size=3.
  - Each returns err=1, rdata=0, in cycle 1.
  - o_mem_valid never rises.
- Back-pressure and gap:
  - Hold i_rsp_ready=0 for 5 cycles: response fields stay stable and o_req_ready stays 0.
  - Over random back-to-back traffic, o_mem_valid never stays high across two transactions.
- Reset: assert i_rst during WR.
  - o_mem_valid drops in the same cycle and no response is produced.
  - After release, o_req_ready=1.
